// File: rtl/benes_cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// benes_cfg_loader_pkg
//
// Shared sizing, types and helpers for the Benes configuration loader.
// The network size lives here so the loader, its shadow bank and benes_top
// all agree on the shape of a configuration.
//
//   SIZE        number of network ports (power of two, >= 4)
//   SWITCH_NUM  2x2 switches per stage
//   STAGE_NUM   Benes stage count
//   IDX_W       width of a stage index
//
// Optional feature macro used by the loader: BENES_CFG_PARITY_EN.
// ---------------------------------------------------------------------------
package benes_cfg_loader_pkg;

    localparam int SIZE       = 8;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int IDX_W      = $clog2(STAGE_NUM);

    typedef logic [SWITCH_NUM-1:0] stage_word_t;
    typedef stage_word_t [0:STAGE_NUM-1] cfg_bank_t;
    typedef logic [STAGE_NUM-1:0] stage_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        COMMIT
    } cfg_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM - 1);

    // STAGE_NUM is always odd, so the index field can encode values that do
    // not name a real stage; those must be rejected.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return idx <= LAST_IDX;
    endfunction

    // One-hot stage mask for an index; an out-of-range index yields zero.
    function automatic stage_mask_t stage_onehot(input logic [IDX_W-1:0] idx);
        stage_mask_t m;
        for (int i = 0; i < STAGE_NUM; i++) begin
            m[i] = (idx == IDX_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/benes_cfg_loader_bank.sv
// ---------------------------------------------------------------------------
// benes_cfg_bank
//
// Shadow register file for the Benes configuration loader. Holds one switch
// word per stage plus a mask recording which stages were written in the
// current load.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset (clears words and mask)
//   wr_en       write the word below into its stage this cycle
//   wr_idx      target stage of the write
//   wr_word     switch bits for that stage
//   clr         clear the loaded mask (words are kept)
//   shadow      current shadow contents
//   all_loaded  every stage is loaded, counting the write presented this cycle
// ---------------------------------------------------------------------------
module benes_cfg_bank
    import benes_cfg_loader_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [IDX_W-1:0]                      wr_idx,
    input  logic [SWITCH_NUM-1:0]                 wr_word,
    input  logic                                  clr,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  shadow,
    output logic                                  all_loaded
);

    stage_mask_t mask;
    stage_mask_t wr_onehot;

    assign wr_onehot = wr_en ? stage_onehot(wr_idx) : '0;

    // The loader decides completion on the same edge as the final write, so
    // the pending write has to be folded in here.
    assign all_loaded = &(mask | wr_onehot);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                if (wr_onehot[i]) begin
                    shadow[i] <= wr_word;
                end
            end
        end
    end

    // Clear has priority so a rejected final beat leaves nothing marked.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (clr) begin
            mask <= '0;
        end else begin
            mask <= mask | wr_onehot;
        end
    end

endmodule

// File: rtl/benes_cfg_loader.sv
// ---------------------------------------------------------------------------
// benes_cfg_loader
//
// Upstream control stage for benes_top. Stage words arrive over a
// valid/ready stream into a shadow bank; once every stage is loaded the
// shadow is copied into the active bank in one cycle on commit_req, so the
// network never sees a half-written configuration.
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   s_valid/s_ready   beat handshake
//   s_idx             target stage of the beat
//   s_word            switch bits, bit k drives switch k, 1 = cross
//   s_last            final beat of the configuration
//   s_par             (BENES_CFG_PARITY_EN only) even parity over
//                     {s_idx, s_word, s_par}
//   commit_req        request to copy shadow to active (honoured in FULL)
//   commit_ack        one-cycle pulse in the cycle the active bank changed
//   cfg_error         sticky error flag for the current load
//   cfg_valid         active bank holds a committed configuration
//   switch_selection  active bank, feeds benes_top
//
// Optional feature: define BENES_CFG_PARITY_EN to add s_par and its check.
// ---------------------------------------------------------------------------
module benes_cfg_loader
    import benes_cfg_loader_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [IDX_W-1:0]                      s_idx,
    input  logic [SWITCH_NUM-1:0]                 s_word,
    input  logic                                  s_last,
`ifdef BENES_CFG_PARITY_EN
    input  logic                                  s_par,
`endif
    input  logic                                  commit_req,
    output logic                                  commit_ack,
    output logic                                  cfg_error,
    output logic                                  cfg_valid,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  switch_selection
);

    cfg_state_t state;
    cfg_state_t state_next;

    logic                                 beat_fire;
    logic                                 par_ok;
    logic                                 beat_ok;
    logic                                 wr_en;
    logic                                 err_so_far;
    logic                                 all_loaded;
    logic                                 last_good;
    logic                                 last_bad;
    logic                                 take_commit;
    logic                                 mask_clr;
    logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] shadow;

`ifdef BENES_CFG_PARITY_EN
    assign par_ok = ~^{s_idx, s_word, s_par};
`else
    assign par_ok = 1'b1;
`endif

    assign beat_fire = s_valid && s_ready;
    assign beat_ok   = idx_in_range(s_idx) && par_ok;
    assign wr_en     = beat_fire && beat_ok;

    // A beat taken in IDLE starts a fresh load, so any error left over from
    // the previous load must not count against it.
    assign err_so_far = (state == IDLE) ? 1'b0 : cfg_error;

    assign last_good   = beat_fire && s_last && all_loaded && beat_ok && !err_so_far;
    assign last_bad    = beat_fire && s_last && !last_good;
    assign take_commit = (state == FULL) && commit_req;

    // Forgetting the mask is what discards an incomplete shadow: a later
    // load has to rewrite every stage before it can reach FULL again.
    assign mask_clr = last_bad || take_commit;

    benes_cfg_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (s_idx),
        .wr_word    (s_word),
        .clr        (mask_clr),
        .shadow     (shadow),
        .all_loaded (all_loaded)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (beat_fire) begin
                    if (s_last) begin
                        state_next = last_good ? FULL : IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat_fire && s_last) begin
                    state_next = last_good ? FULL : IDLE;
                end
            end
            FULL: begin
                if (commit_req) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        s_ready    = 1'b0;
        commit_ack = 1'b0;
        case (state)
            IDLE:    s_ready    = 1'b1;
            LOAD:    s_ready    = 1'b1;
            COMMIT:  commit_ack = 1'b1;
            default: s_ready    = 1'b0;
        endcase
    end

    // Error flag: recomputed on every accepted beat, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_error <= 1'b0;
        end else if (beat_fire) begin
            cfg_error <= err_so_far || !beat_ok || last_bad;
        end
    end

    // The active bank is loaded on the edge that enters COMMIT so the new
    // configuration appears in the same cycle as commit_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            switch_selection <= '0;
            cfg_valid        <= 1'b0;
        end else if (take_commit) begin
            switch_selection <= shadow;
            cfg_valid        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_benes_cfg_loader
//
// Directed bench for benes_cfg_loader. Honoured commits push the expected
// active bank and acknowledge cycle into a queue; a monitor pops and checks
// whenever commit_ack is seen, and flags any acknowledge nobody asked for.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_benes_cfg_loader;
    import benes_cfg_loader_pkg::*;

    typedef struct {
        cfg_bank_t bank;
        int        ack_cyc;
    } exp_t;

    localparam cfg_bank_t BANK_ZERO = '0;
    localparam cfg_bank_t BANK_A    = 20'hFD955;
    localparam cfg_bank_t BANK_B    = 20'h12483;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_valid;
    logic                  s_ready;
    logic [IDX_W-1:0]      s_idx;
    logic [SWITCH_NUM-1:0] s_word;
    logic                  s_last;
`ifdef BENES_CFG_PARITY_EN
    logic                  s_par;
`endif
    logic                  bad_par = 1'b0;
    logic                  commit_req;
    logic                  commit_ack;
    logic                  cfg_error;
    logic                  cfg_valid;
    cfg_bank_t             switch_selection;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    benes_cfg_loader dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_idx            (s_idx),
        .s_word           (s_word),
        .s_last           (s_last),
`ifdef BENES_CFG_PARITY_EN
        .s_par            (s_par),
`endif
        .commit_req       (commit_req),
        .commit_ack       (commit_ack),
        .cfg_error        (cfg_error),
        .cfg_valid        (cfg_valid),
        .switch_selection (switch_selection)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: every acknowledge must match a queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (commit_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: commit_ack=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                checkOutput("ack_bank", 32'(switch_selection), 32'(mon_e.bank));
                checkOutput("ack_cfg_valid", 32'(cfg_valid), 32'd1);
            end
        end
    end

    // Present one beat and hold it until it is accepted.
    task automatic applyStimulus(input int idx, input logic [SWITCH_NUM-1:0] word, input logic last);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_idx   = IDX_W'(idx);
        s_word  = word;
        s_last  = last;
`ifdef BENES_CFG_PARITY_EN
        s_par   = (^{s_idx, s_word}) ^ bad_par;
`endif
        while (s_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: s_ready=%b, expected 1 within 20 cycles", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Pulse commit_req for one cycle; queue the expectation if it should be taken.
    task automatic commitReq(input logic expect_ack, input cfg_bank_t bank);
        exp_t e;
        commit_req = 1'b1;
        if (expect_ack) begin
            e.bank    = bank;
            e.ack_cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        commit_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic loadBank(input cfg_bank_t bank);
        for (int i = 0; i < STAGE_NUM; i++) begin
            applyStimulus(i, bank[i], (i == STAGE_NUM - 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_idx      = '0;
        s_word     = '0;
        s_last     = 1'b0;
`ifdef BENES_CFG_PARITY_EN
        s_par      = 1'b0;
`endif
        commit_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        checkOutput("rst_switch_sel", 32'(switch_selection), 32'(BANK_ZERO));
        checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
        checkOutput("rst_commit_ack", 32'(commit_ack), 32'd0);
        checkOutput("rst_cfg_error", 32'(cfg_error), 32'd0);

        // Full load with a duplicate write to stage 2, then commit.
        applyStimulus(0, 4'b1111, 1'b0);
        applyStimulus(1, 4'b1101, 1'b0);
        applyStimulus(2, 4'b0000, 1'b0);
        applyStimulus(2, 4'b1001, 1'b0);
        applyStimulus(3, 4'b0101, 1'b0);
        applyStimulus(4, 4'b0101, 1'b1);
        checkOutput("full_s_ready", 32'(s_ready), 32'd0);
        checkOutput("full_cfg_error", 32'(cfg_error), 32'd0);
        commitReq(1'b1, BANK_A);
        checkOutput("a_switch_sel", 32'(switch_selection), 32'(BANK_A));
        checkOutput("a_cfg_valid", 32'(cfg_valid), 32'd1);
        checkOutput("a_s_ready", 32'(s_ready), 32'd1);

        // Missing stage 2: error, back to IDLE, commit ignored.
        applyStimulus(0, 4'b1111, 1'b0);
        applyStimulus(1, 4'b1111, 1'b0);
        applyStimulus(3, 4'b1111, 1'b0);
        applyStimulus(4, 4'b1111, 1'b1);
        checkOutput("miss_cfg_error", 32'(cfg_error), 32'd1);
        checkOutput("miss_s_ready", 32'(s_ready), 32'd1);
        commitReq(1'b0, BANK_ZERO);
        checkOutput("miss_switch_sel", 32'(switch_selection), 32'(BANK_A));

        // Out-of-range index, then a clean reload that commits.
        applyStimulus(6, 4'b1010, 1'b1);
        checkOutput("oor_cfg_error", 32'(cfg_error), 32'd1);
        checkOutput("oor_s_ready", 32'(s_ready), 32'd1);
        applyStimulus(0, 4'b0001, 1'b0);
        checkOutput("reload_err_clr", 32'(cfg_error), 32'd0);
        applyStimulus(1, 4'b0010, 1'b0);
        applyStimulus(2, 4'b0100, 1'b0);
        applyStimulus(3, 4'b1000, 1'b0);
        applyStimulus(4, 4'b0011, 1'b1);
        checkOutput("reload_s_ready", 32'(s_ready), 32'd0);

        // Commit and a beat in the same FULL cycle: commit wins.
        commit_req = 1'b1;
        s_valid    = 1'b1;
        s_idx      = '0;
        s_word     = 4'b1111;
        s_last     = 1'b1;
`ifdef BENES_CFG_PARITY_EN
        s_par      = ^{s_idx, s_word};
`endif
        e.bank    = BANK_B;
        e.ack_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("commit_s_ready", 32'(s_ready), 32'd0);
        commit_req = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("b_switch_sel", 32'(switch_selection), 32'(BANK_B));
        checkOutput("b_cfg_error", 32'(cfg_error), 32'd0);

        // Commit requests outside FULL are ignored.
        commitReq(1'b0, BANK_ZERO);
        applyStimulus(0, 4'b0111, 1'b0);
        applyStimulus(1, 4'b0111, 1'b0);
        applyStimulus(2, 4'b0111, 1'b0);
        commitReq(1'b0, BANK_ZERO);
        checkOutput("load_switch_sel", 32'(switch_selection), 32'(BANK_B));

        // Reset in the middle of a load.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_switch_sel", 32'(switch_selection), 32'(BANK_ZERO));
        checkOutput("mid_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("mid_s_ready", 32'(s_ready), 32'd1);
        checkOutput("mid_cfg_error", 32'(cfg_error), 32'd0);
        checkOutput("mid_commit_ack", 32'(commit_ack), 32'd0);
        commitReq(1'b0, BANK_ZERO);
        checkOutput("mid_post_commit", 32'(switch_selection), 32'(BANK_ZERO));

        // Stages written before the reset must not count toward completion.
        applyStimulus(3, 4'b0111, 1'b0);
        applyStimulus(4, 4'b0111, 1'b1);
        checkOutput("partial_cfg_error", 32'(cfg_error), 32'd1);
        checkOutput("partial_s_ready", 32'(s_ready), 32'd1);

`ifdef BENES_CFG_PARITY_EN
        // Bad parity on stage 1 is rejected like an out-of-range index.
        applyStimulus(0, 4'b1111, 1'b0);
        checkOutput("par_pre_error", 32'(cfg_error), 32'd0);
        bad_par = 1'b1;
        applyStimulus(1, 4'b0110, 1'b0);
        bad_par = 1'b0;
        checkOutput("par_cfg_error", 32'(cfg_error), 32'd1);
        applyStimulus(2, 4'b0110, 1'b0);
        applyStimulus(3, 4'b0110, 1'b0);
        applyStimulus(4, 4'b0110, 1'b1);
        checkOutput("par_load_fail", 32'(s_ready), 32'd1);
        loadBank(BANK_A);
        checkOutput("par_good_error", 32'(cfg_error), 32'd0);
        commitReq(1'b1, BANK_A);
        checkOutput("par_switch_sel", 32'(switch_selection), 32'(BANK_A));
`else
        loadBank(BANK_A);
        commitReq(1'b1, BANK_A);
        checkOutput("final_switch_sel", 32'(switch_selection), 32'(BANK_A));
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/benes_cfg_loader.md
Name: benes_cfg_loader

Overview:
- Upstream control stage for benes_top.
- Accepts Benes switch-control words over a valid/ready stream, one stage word per beat, into a shadow bank.
- Once all stages are loaded, commits the shadow bank atomically to the active bank on request. The active bank drives benes_top's switch_selection, so the network never sees a partially updated configuration.

Parameters:
- SIZE, 8, number of network ports (power of two, >=4).
- SWITCH_NUM, SIZE/2, 2x2 switches per stage.
- STAGE_NUM, 2*$clog2(SIZE)-1, Benes stage count (5 for SIZE=8).
- IDX_W, $clog2(STAGE_NUM), width of the stage index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat.
- s_idx  in  IDX_W  target stage of the beat.
- s_word  in  SWITCH_NUM  switch bits for the stage; bit k drives switch k, 1 = cross.
- s_last  in  1  final beat of the configuration.
- commit_req  in  1  request to transfer shadow to active.
- commit_ack  out  1  one-cycle pulse; the active bank was updated this cycle.
- cfg_error  out  1  sticky error flag for the current load.
- cfg_valid  out  1  active bank holds a committed configuration.
- switch_selection  out  [SWITCH_NUM-1:0] x [0:STAGE_NUM-1]  active bank, feeds benes_top.

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM enters IDLE.
  - Shadow bank, active bank and loaded mask clear to 0, so all switches are bar.
  - s_ready=1, commit_ack=0, cfg_error=0, cfg_valid=0.
- A beat is accepted when s_valid && s_ready at a clk edge.
- FSM states:
  - IDLE: accepted beat goes to LOAD and clears cfg_error.
  - LOAD: writes continue.
  - FULL: s_ready=0; waits for commit.
  - COMMIT: one cycle; goes to IDLE.
- Accepted beat handling:
  - shadow[s_idx] <= s_word and mask[s_idx] <= 1.
  - A duplicate s_idx overwrites the stored word; this is legal.
- Index check: s_idx >= STAGE_NUM sets cfg_error, writes nothing, and the FSM continues.
- s_last accepted:
  - Mask, including this beat, is all ones and no error occurred -> FULL.
  - Otherwise cfg_error=1, mask clears, FSM -> IDLE, and shadow contents are discarded for commit purposes.
- commit_req:
  - Honoured only in FULL. The next edge enters COMMIT, where active <= shadow, commit_ack=1, cfg_valid=1 and mask clears.
  - Ignored in any other state; no ack is given.
- Latency: commit_req sampled in FULL -> switch_selection changes 1 cycle later, in the same cycle as commit_ack.
- s_ready=0 in FULL and COMMIT; s_ready=1 in IDLE and LOAD.
- Simultaneous commit_req and s_valid in FULL: the commit is taken and the beat is not accepted. Loading resumes from IDLE on the following cycle.
- The active bank holds its value through all loads; it changes only in COMMIT or on reset.
- Reset mid-load or mid-commit: full reset as above. A partial shadow is never committed.
- cfg_error clears only on the first accepted beat of a new load, or on reset.

Optional Feature:
- Macro: BENES_CFG_PARITY_EN.
- Defined:
  - Adds input s_par (1 bit); even parity is required over {s_idx, s_word, s_par}.
  - A mismatch is treated exactly like an out-of-range index: error set, no write.
- Undefined: the port is absent and no parity check is made.

Decomposition:
- Shared BENES_PKG (with USER_PARAM_PKG values) holds:
  - typedef stage_word_t = logic [SWITCH_NUM-1:0].
  - typedef cfg_bank_t = stage_word_t [0:STAGE_NUM-1].
  - typedef enum cfg_state_t {IDLE, LOAD, FULL, COMMIT}.
  - Constant IDX_W.
- One sub-module, benes_cfg_bank, holds the shadow register file plus loaded mask, with write, clear and all_loaded outputs. The FSM and active bank stay in the top.

Test Plan:
- Reset, no beats -> switch_selection all 4'b0000, cfg_valid=0, s_ready=1, commit_ack=0.
- Load idx 0..4 with 4'b1111, 4'b1101, 4'b1001, 4'b0101, 4'b0101 (last on idx 4), then commit_req -> s_ready=0 after the last beat. Exactly one commit_ack pulse, one cycle after the request. switch_selection equals these values and cfg_valid=1.
- After that config, load all stages 4'b1111 but omit idx 2 and assert s_last on idx 4 -> cfg_error=1 and FSM returns to IDLE. A subsequent commit_req gives no ack and the active bank keeps the previous values.
- Beat with s_idx=6 -> cfg_error=1 and no write. Then a full valid reload -> cfg_error clears on its first beat and the commit succeeds.
- commit_req pulsed in IDLE and LOAD -> no ack and no change. Assert rst mid-LOAD (after 3 beats) -> all outputs return to their reset values and a following commit_req is ignored.
- With BENES_CFG_PARITY_EN defined: a beat with bad s_par on idx 1 -> cfg_error=1 and shadow[1] unchanged. Good-parity beats behave as in the second scenario.
